uart_rx_param: RTL and testbench

//  Parametrised UART receiver: successor to the fixed 8N1 receiver. Configurable data width,

---
 rtl/uart_rx_param_pkg.sv | 29 ++
 rtl/uart_rx_param_if.sv | 21 ++
 rtl/uart_rx_param_sync_2ff.sv | 24 ++
 rtl/uart_rx_param.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_param_pkg.sv
// Shared constants, state encoding and parity helper for the parameterised UART receiver.
package uart_rx_param_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK,
        ST_DONE
    } rx_state_e;

    // ones_x is the XOR of all data bits and the received parity bit.
    function automatic logic parity_error(input int unsigned mode, input logic ones_x);
        if (mode == PARITY_ODD) begin
            return ~ones_x;
        end
        if (mode == PARITY_EVEN) begin
            return ones_x;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side valid/ready handshake with per-word error flags and overrun pulse.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] RX_DATA;
    logic                 RX_VALID;
    logic                 RX_READY;
    logic                 RX_PARITY_ERR;
    logic                 RX_FRAME_ERR;
    logic                 RX_OVERRUN;

    modport master (
        output RX_DATA, RX_VALID, RX_PARITY_ERR, RX_FRAME_ERR, RX_OVERRUN,
        input  RX_READY
    );

    modport slave (
        input  RX_DATA, RX_VALID, RX_PARITY_ERR, RX_FRAME_ERR, RX_OVERRUN,
        output RX_READY
    );
endinterface

// File: rtl/uart_rx_param_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with selectable reset value.
module uart_rx_param_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: configurable data width, parity and stop bits,
// delivering each frame with error flags on a valid/ready interface.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            UART_RXD,
    uart_rx_param_if.master rx,
    output logic            RX_BUSY
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    logic rxd_s;

    uart_rx_param_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .d     (UART_RXD),
        .q     (rxd_s)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 deliver;
    logic                 ferr_next;

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rperr_q, rperr_d;
    logic                 rferr_q, rferr_d;
    logic                 ovr_q, ovr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        deliver   = 1'b0;
        ferr_next = ferr_q | ~rxd_s;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (!rxd_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // Right shift lands the first received bit in bit 0 after DATA_BITS samples.
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = parity_error(PARITY, (^shift_q) ^ rxd_s);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    ferr_d = ferr_next;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = ferr_next ? ST_BREAK : ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                if (rxd_s) state_d = ST_DONE;
            end
            ST_DONE: begin
                deliver = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        rperr_d = rperr_q;
        rferr_d = rferr_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || rx.RX_READY) begin
                valid_d = 1'b1;
                rdata_d = shift_q;
                rperr_d = perr_q;
                rferr_d = ferr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx.RX_READY) begin
            valid_d = 1'b0;
            rperr_d = 1'b0;
            rferr_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            rperr_q <= 1'b0;
            rferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            rperr_q <= rperr_d;
            rferr_q <= rferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.RX_DATA       = rdata_q;
    assign rx.RX_VALID      = valid_q;
    assign rx.RX_PARITY_ERR = rperr_q;
    assign rx.RX_FRAME_ERR  = rferr_q;
    assign rx.RX_OVERRUN    = ovr_q;
    assign RX_BUSY          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised and directed checks of three receiver configurations (8N1, 7E1, 8O2)
// against a frame-level reference model.
module tb_uart_rx_param;
    localparam int unsigned CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rxd = '1;
    logic [2:0] busy;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    vcyc[3]  = '{0, 0, 0};
    int    ovr[3]   = '{0, 0, 0};
    word_t acc0[$];
    word_t acc1[$];
    word_t acc2[$];

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(7)) if_b ();
    uart_rx_param_if #(.DATA_BITS(8)) if_c ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .UART_RXD(rxd[0]), .rx(if_a), .RX_BUSY(busy[0]));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .UART_RXD(rxd[1]), .rx(if_b), .RX_BUSY(busy[1]));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_c (
        .CLOCK_50(clk), .RESET_N(rst_n), .UART_RXD(rxd[2]), .rx(if_c), .RX_BUSY(busy[2]));

    always @(negedge clk) begin
        if (if_a.RX_VALID) vcyc[0] <= vcyc[0] + 1;
        if (if_b.RX_VALID) vcyc[1] <= vcyc[1] + 1;
        if (if_c.RX_VALID) vcyc[2] <= vcyc[2] + 1;
        if (if_a.RX_OVERRUN) ovr[0] <= ovr[0] + 1;
        if (if_b.RX_OVERRUN) ovr[1] <= ovr[1] + 1;
        if (if_c.RX_OVERRUN) ovr[2] <= ovr[2] + 1;
        if (if_a.RX_VALID && if_a.RX_READY)
            acc0.push_back('{data: 9'(if_a.RX_DATA), perr: if_a.RX_PARITY_ERR, ferr: if_a.RX_FRAME_ERR});
        if (if_b.RX_VALID && if_b.RX_READY)
            acc1.push_back('{data: 9'(if_b.RX_DATA), perr: if_b.RX_PARITY_ERR, ferr: if_b.RX_FRAME_ERR});
        if (if_c.RX_VALID && if_c.RX_READY)
            acc2.push_back('{data: 9'(if_c.RX_DATA), perr: if_c.RX_PARITY_ERR, ferr: if_c.RX_FRAME_ERR});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_bits(input int d);
        return (d == 1) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction
    function automatic int cfg_stop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // Reference rule: odd mode wants an odd count of ones over data+parity, even mode an even count.
    function automatic logic model_perr(input int pm, input logic [8:0] data, input logic pb);
        int ones;
        ones = $countones(data) + int'(pb);
        if (pm == 0) return 1'b0;
        if (pm == 1) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    function automatic int q_size(input int d);
        if (d == 0) return acc0.size();
        if (d == 1) return acc1.size();
        return acc2.size();
    endfunction

    task automatic q_pop(input int d, output word_t w);
        if (d == 0) w = acc0.pop_front();
        else if (d == 1) w = acc1.pop_front();
        else w = acc2.pop_front();
    endtask

    task automatic set_ready(input int d, input logic v);
        if (d == 0) if_a.RX_READY = v;
        else if (d == 1) if_b.RX_READY = v;
        else if_c.RX_READY = v;
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int d, input logic b);
        rxd[d] = b;
        idle(CPB);
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input logic flip,
                              input logic stop0, input logic stop1, output logic pb);
        int nb;
        nb = cfg_bits(d);
        pb = 1'b0;
        drive_bit(d, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d, data[i]);
        if (cfg_par(d) != 0) begin
            pb = (cfg_par(d) == 2) ? 1'($countones(data) % 2) : 1'(($countones(data) + 1) % 2);
            pb = pb ^ flip;
            drive_bit(d, pb);
        end
        drive_bit(d, stop0);
        if (cfg_stop(d) == 2) drive_bit(d, stop1);
        rxd[d] = 1'b1;
    endtask

    task automatic expect_word(input string tag, input int d, input logic [8:0] data,
                               input logic perr, input logic ferr);
        word_t w;
        logic  seen;
        seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            if (q_size(d) != 0) seen = 1'b1;
            else idle(1);
        end
        check({tag, "_arrived"}, 32'(seen), 32'd1);
        if (seen) begin
            q_pop(d, w);
            check({tag, "_data"}, 32'(w.data), 32'(data));
            check({tag, "_perr"}, 32'(w.perr), 32'(perr));
            check({tag, "_ferr"}, 32'(w.ferr), 32'(ferr));
        end
    endtask

    initial begin
        logic [8:0] data;
        logic       pb, flip, s0, s1;
        int         base_v, base_o;

        rst_n = 1'b0;
        if_a.RX_READY = 1'b1;
        if_b.RX_READY = 1'b1;
        if_c.RX_READY = 1'b1;
        idle(3);
        check("reset_valid_a", 32'(if_a.RX_VALID), 32'd0);
        check("reset_data_c", 32'(if_c.RX_DATA), 32'd0);
        check("reset_flags_b", {30'd0, if_b.RX_PARITY_ERR, if_b.RX_FRAME_ERR}, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // 8N1 0xA5, single-cycle valid with ready held high
        base_v = vcyc[0];
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1, pb);
        expect_word("t1", 0, 9'h0A5, 1'b0, 1'b0);
        idle(4);
        check("t1_valid_cycles", 32'(vcyc[0] - base_v), 32'd1);

        // 7E1: 0x03 with wrong then right parity bit
        send_frame(1, 9'h003, 1'b1, 1'b1, 1'b1, pb);
        check("t2_pbit_sent", 32'(pb), 32'd1);
        expect_word("t2a", 1, 9'h003, 1'b1, 1'b0);
        send_frame(1, 9'h003, 1'b0, 1'b1, 1'b1, pb);
        expect_word("t2b", 1, 9'h003, 1'b0, 1'b0);

        // 5-cycle glitch
        base_v = vcyc[0];
        rxd[0] = 1'b0;
        idle(5);
        rxd[0] = 1'b1;
        idle(10);
        check("t3_busy_dropped", 32'(busy[0]), 32'd0);
        idle(40);
        check("t3_no_valid", 32'(vcyc[0] - base_v), 32'd0);

        // Line held low for 20 bit times
        rxd[0] = 1'b0;
        idle(20 * CPB);
        rxd[0] = 1'b1;
        expect_word("t4_break", 0, 9'h000, 1'b0, 1'b1);
        idle(3 * CPB);
        check("t4_single_word", 32'(q_size(0)), 32'd0);
        send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1, pb);
        expect_word("t4_after", 0, 9'h03C, 1'b0, 1'b0);

        // Overrun with consumer stalled
        set_ready(0, 1'b0);
        base_o = ovr[0];
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1, pb);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1, pb);
        idle(2 * CPB);
        check("t5_valid_held", 32'(if_a.RX_VALID), 32'd1);
        check("t5_data_held", 32'(if_a.RX_DATA), 32'h11);
        check("t5_overrun_pulses", 32'(ovr[0] - base_o), 32'd1);
        set_ready(0, 1'b1);
        expect_word("t5_accept", 0, 9'h011, 1'b0, 1'b0);
        idle(2);
        check("t5_valid_low", 32'(if_a.RX_VALID), 32'd0);
        idle(2 * CPB);
        check("t5_dropped", 32'(q_size(0)), 32'd0);

        // 8O2: async reset during data, with an unaccepted errored word held
        set_ready(2, 1'b0);
        send_frame(2, 9'h042, 1'b1, 1'b1, 1'b1, pb);
        idle(2 * CPB);
        check("t6_held_valid", 32'(if_c.RX_VALID), 32'd1);
        check("t6_held_perr", 32'(if_c.RX_PARITY_ERR), 32'd1);
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(if_c.RX_VALID), 32'd0);
        check("t6_rst_data", 32'(if_c.RX_DATA), 32'd0);
        check("t6_rst_flags", {29'd0, if_c.RX_PARITY_ERR, if_c.RX_FRAME_ERR, if_c.RX_OVERRUN}, 32'd0);
        check("t6_rst_busy", 32'(busy[2]), 32'd0);
        rxd[2] = 1'b1;
        idle(3);
        rst_n = 1'b1;
        set_ready(2, 1'b1);
        idle(4);
        send_frame(2, 9'h05A, 1'b0, 1'b1, 1'b1, pb);
        expect_word("t6_after", 2, 9'h05A, 1'b0, 1'b0);
        idle(2 * CPB);
        check("t6_no_stale", 32'(q_size(2)), 32'd0);

        // Random frames on every configuration
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                data = 9'($urandom) & ((9'd1 << cfg_bits(d)) - 9'd1);
                flip = (cfg_par(d) != 0) && ($urandom_range(0, 3) == 0);
                s0   = ($urandom_range(0, 4) != 0);
                s1   = ($urandom_range(0, 4) != 0);
                send_frame(d, data, flip, s0, s1, pb);
                expect_word($sformatf("rnd_d%0d_%0d", d, k), d, data,
                            model_perr(cfg_par(d), data, pb),
                            !s0 || (cfg_stop(d) == 2 && !s1));
                idle($urandom_range(0, 20));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
